// File: rtl/ssm_instr_dispatcher_pkg.sv
// Shared constants for the instruction dispatcher: opcodes, FSM indices, states, error codes.
package ssm_dispatch_pkg;

   localparam logic [3:0] OP_ALU_MAX  = 4'h7;
   localparam logic [3:0] OP_ALUI_MAX = 4'h9;
   localparam logic [3:0] OP_MOVE     = 4'hA;
   localparam logic [3:0] OP_MOVI     = 4'hB;
   localparam logic [3:0] OP_LOAD     = 4'hC;
   localparam logic [3:0] OP_STORE    = 4'hD;
   localparam logic [3:0] OP_NOP      = 4'hE;
   localparam logic [3:0] OP_HALT     = 4'hF;

   localparam int FSM_ALU   = 0;
   localparam int FSM_ALUI  = 1;
   localparam int FSM_MOVE  = 2;
   localparam int FSM_MOVI  = 3;
   localparam int FSM_LOAD  = 4;
   localparam int FSM_STORE = 5;

   typedef enum logic [2:0] {
      ST_IDLE, ST_DECODE, ST_START, ST_WAIT, ST_RETIRE, ST_HALT, ST_ERROR
   } state_e;

   localparam logic [1:0] ERR_NONE       = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT    = 2'b01;
   localparam logic [1:0] ERR_BAD_DONE   = 2'b10;
   localparam logic [1:0] ERR_STRAY_DONE = 2'b11;

   typedef struct packed {
      logic [3:0] opcode;
      logic [5:0] param1;
      logic [5:0] param2;
   } instr_t;

endpackage

// File: rtl/ssm_instr_dispatcher_if.sv
// Fetch/execution-side bus of the dispatcher; master = fetch + execution FSMs, slave = dispatcher.
interface ssm_instr_dispatcher_if #(
   parameter int NUM_FSM = 6
);
   logic               instr_valid;
   logic [15:0]        instruction;
   logic               instr_ready;
   logic [3:0]         opcode;
   logic [5:0]         param1;
   logic [5:0]         param2;
   logic [NUM_FSM-1:0] fsm_start;
   logic [NUM_FSM-1:0] fsm_done;
   logic               retire;
   logic               busy;
   logic               halted;
   logic               error;
   logic [1:0]         err_code;
   logic               err_clear;

   modport master (
      output instr_valid, instruction, fsm_done, err_clear,
      input  instr_ready, opcode, param1, param2, fsm_start, retire, busy, halted, error, err_code
   );

   modport slave (
      input  instr_valid, instruction, fsm_done, err_clear,
      output instr_ready, opcode, param1, param2, fsm_start, retire, busy, halted, error, err_code
   );
endinterface

// File: rtl/ssm_instr_dispatcher_opcode_decoder.sv
// Combinational opcode classifier: one-hot execution FSM select plus NOP/HALT flags.
module ssm_opcode_decoder
   import ssm_dispatch_pkg::*;
#(
   parameter int NUM_FSM = 6
) (
   input  logic [3:0]         i_opcode,
   output logic [NUM_FSM-1:0] o_sel,
   output logic               o_is_nop,
   output logic               o_is_halt
);

   always_comb begin
      o_sel     = '0;
      o_is_nop  = 1'b0;
      o_is_halt = 1'b0;
      if (i_opcode <= OP_ALU_MAX)       o_sel[FSM_ALU]  = 1'b1;
      else if (i_opcode <= OP_ALUI_MAX) o_sel[FSM_ALUI] = 1'b1;
      else begin
         case (i_opcode)
            OP_MOVE:  o_sel[FSM_MOVE]  = 1'b1;
            OP_MOVI:  o_sel[FSM_MOVI]  = 1'b1;
            OP_LOAD:  o_sel[FSM_LOAD]  = 1'b1;
            OP_STORE: o_sel[FSM_STORE] = 1'b1;
            OP_NOP:   o_is_nop         = 1'b1;
            default:  o_is_halt        = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/ssm_instr_dispatcher.sv
// Dispatcher between fetch and the per-class execution FSMs; one instruction in flight at a time.
// Optional perf counters (retires, WAIT cycles) are built when SSM_DISPATCH_PERF_EN is defined.
module ssm_instr_dispatcher
   import ssm_dispatch_pkg::*;
#(
   parameter int NUM_FSM        = 6,
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   ssm_instr_dispatcher_if.slave bus
`ifdef SSM_DISPATCH_PERF_EN
   ,
   output logic [15:0]           o_perf_retired,
   output logic [15:0]           o_perf_wait_cycles
`endif
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_e             r_state, w_next;
   instr_t             r_instr;
   logic [1:0]         r_err_code, w_err_next;
   logic [CW-1:0]      r_cnt;
   logic [NUM_FSM-1:0] w_sel;
   logic               w_is_nop, w_is_halt;
   logic               w_accept, w_done_any, w_done_ok, w_timeout;

   ssm_opcode_decoder #(.NUM_FSM(NUM_FSM)) u_dec (
      .i_opcode  (r_instr.opcode),
      .o_sel     (w_sel),
      .o_is_nop  (w_is_nop),
      .o_is_halt (w_is_halt)
   );

   assign bus.instr_ready = (r_state == ST_IDLE) & i_reset;
   assign bus.opcode      = r_instr.opcode;
   assign bus.param1      = r_instr.param1;
   assign bus.param2      = r_instr.param2;
   assign bus.err_code    = r_err_code;

   assign w_accept   = bus.instr_valid & bus.instr_ready;
   assign w_done_any = |bus.fsm_done;
   assign w_done_ok  = (bus.fsm_done == w_sel);
   // Counter holds WAIT cycles already elapsed; the last one expires the budget.
   assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= ST_IDLE;
         r_instr    <= '0;
         r_err_code <= ERR_NONE;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_next;
         r_err_code <= w_err_next;
         if (w_accept) r_instr <= instr_t'(bus.instruction);
         if (r_state == ST_START)                   r_cnt <= '0;
         else if (r_state == ST_WAIT && r_cnt != '1) r_cnt <= r_cnt + CW'(1);
      end
   end

   always_comb begin
      w_next        = r_state;
      w_err_next    = r_err_code;
      bus.fsm_start = '0;
      bus.retire    = 1'b0;
      bus.busy      = (r_state != ST_IDLE);
      bus.halted    = 1'b0;
      bus.error     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_done_any) begin
               w_next     = ST_ERROR;
               w_err_next = ERR_STRAY_DONE;
            end else if (w_accept) begin
               w_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (w_done_any) begin
               w_next     = ST_ERROR;
               w_err_next = ERR_STRAY_DONE;
            end else if (w_is_halt) w_next = ST_HALT;
            else if (w_is_nop)      w_next = ST_RETIRE;
            else                    w_next = ST_START;
         end
         ST_START: begin
            bus.fsm_start = w_sel;
            // A done here would predate the start edge the FSM has not yet seen.
            if (w_done_any) begin
               w_next     = ST_ERROR;
               w_err_next = ERR_STRAY_DONE;
            end else begin
               w_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (w_done_any && !w_done_ok) begin
               w_next     = ST_ERROR;
               w_err_next = ERR_BAD_DONE;
            end else if (w_done_any) begin
               w_next = ST_RETIRE;
            end else if (w_timeout) begin
               w_next     = ST_ERROR;
               w_err_next = ERR_TIMEOUT;
            end
         end
         ST_RETIRE: begin
            bus.retire = 1'b1;
            if (w_done_any) begin
               w_next     = ST_ERROR;
               w_err_next = ERR_STRAY_DONE;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_HALT: bus.halted = 1'b1;
         ST_ERROR: begin
            bus.error = 1'b1;
            if (bus.err_clear) begin
               w_next     = ST_IDLE;
               w_err_next = ERR_NONE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

`ifdef SSM_DISPATCH_PERF_EN
   logic [15:0] r_perf_retired, r_perf_wait;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_perf_retired <= '0;
         r_perf_wait    <= '0;
      end else begin
         if (r_state == ST_RETIRE && r_perf_retired != 16'hFFFF) r_perf_retired <= r_perf_retired + 16'd1;
         if (r_state == ST_WAIT && r_perf_wait != 16'hFFFF)      r_perf_wait    <= r_perf_wait + 16'd1;
      end
   end

   assign o_perf_retired     = r_perf_retired;
   assign o_perf_wait_cycles = r_perf_wait;
`endif

endmodule

// File: tb/tb_ssm_instr_dispatcher.sv
// Randomized bench: acts as fetch and execution FSMs, checks against a transaction-level model.
module tb_ssm_instr_dispatcher;

   localparam int NF = 6;
   localparam int TO = 32;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_chk = 0;
   int   n_bad = 0;
   int   exp_ret = 0;
   int   exp_wait = 0;
   int   cls_of[16];

   ssm_instr_dispatcher_if #(.NUM_FSM(NF)) bus();

`ifdef SSM_DISPATCH_PERF_EN
   logic [15:0] perf_ret, perf_wait;
`endif

   ssm_instr_dispatcher #(.NUM_FSM(NF), .TIMEOUT_CYCLES(TO)) dut (
      .i_clock (clock),
      .i_reset (reset),
      .bus     (bus.slave)
`ifdef SSM_DISPATCH_PERF_EN
      ,
      .o_perf_retired     (perf_ret),
      .o_perf_wait_cycles (perf_wait)
`endif
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [27:0] all_outs();
      return {bus.fsm_start, bus.retire, bus.busy, bus.halted, bus.error, bus.err_code,
              bus.opcode, bus.param1, bus.param2};
   endfunction

   task automatic perf_chk(input string tag);
`ifdef SSM_DISPATCH_PERF_EN
      chk({tag, "_ret"}, {16'h0, perf_ret}, exp_ret);
      chk({tag, "_wait"}, {16'h0, perf_wait}, exp_wait);
`else
      chk({tag, "_idle"}, {bus.instr_ready, bus.busy}, 2'b10);
`endif
   endtask

   // One full instruction; dly = cycles from start pulse to done.
   task automatic run_instr(input logic [15:0] ins, input int dly, input bit hold);
      int         c;
      logic [5:0] oh;
      c = cls_of[ins[15:12]];
      chk("rdy_pre", bus.instr_ready, 1);
      bus.instruction = ins;
      bus.instr_valid = 1'b1;
      tick;
      if (hold) bus.instruction = 16'($urandom);
      else      bus.instr_valid = 1'b0;
      chk("dec_busy", {bus.busy, bus.instr_ready, bus.fsm_start}, 8'h80);
      chk("fields", {bus.opcode, bus.param1, bus.param2}, ins);
      if (c < 0) begin
         tick;
         chk("nop_ret", {bus.retire, bus.fsm_start}, 7'h40);
      end else begin
         oh = 6'(1) << c;
         tick;
         chk("start", bus.fsm_start, oh);
         for (int k = 1; k <= dly; k++) begin
            tick;
            if (k == dly) bus.fsm_done = oh;
            chk("wait_quiet", {bus.fsm_start, bus.retire, bus.busy, bus.error}, 9'b000000010);
         end
         tick;
         bus.fsm_done = '0;
         chk("retire", {bus.retire, bus.fsm_start, bus.error}, 8'h80);
         exp_wait += dly;
      end
      chk("held", {bus.opcode, bus.param1, bus.param2}, ins);
      exp_ret++;
      bus.instr_valid = 1'b0;
      tick;
      chk("idle_after", {bus.instr_ready, bus.busy, bus.retire, bus.error}, 4'b1000);
   endtask

   // Start an FSM instruction and stop in its START cycle.
   task automatic to_start(input logic [15:0] ins);
      bus.instruction = ins;
      bus.instr_valid = 1'b1;
      tick;
      bus.instr_valid = 1'b0;
      tick;
      chk("start2", bus.fsm_start, 6'(1) << cls_of[ins[15:12]]);
   endtask

   task automatic clr_err;
      bus.err_clear = 1'b1;
      tick;
      bus.err_clear = 1'b0;
      chk("clr", {bus.error, bus.err_code, bus.instr_ready, bus.busy}, 5'b00010);
   endtask

   initial begin
      for (int i = 0; i < 16; i++)
         cls_of[i] = (i < 8) ? 0 : (i < 10) ? 1 : (i < 14) ? i - 8 : (i == 14) ? -1 : -2;
      bus.instr_valid = 1'b0;
      bus.instruction = '0;
      bus.fsm_done    = '0;
      bus.err_clear   = 1'b0;

      #1;
      chk("rst_outs", all_outs(), 0);
      chk("rst_rdy", bus.instr_ready, 0);
      #11 reset = 1'b1;
      tick;
      chk("rdy_up", {bus.instr_ready, all_outs()}, 29'h1000_0000);

      run_instr(16'h1041, 3, 1'b0);
      run_instr(16'hE000, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         logic [15:0] ins;
         ins = 16'($urandom);
         ins[15:12] = 4'($urandom_range(0, 14));
         run_instr(ins, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
      end
      perf_chk("perf_mid");

      // Wrong FSM reports done.
      to_start(16'hA083);
      tick;
      bus.fsm_done = 6'b000001;
      tick;
      bus.fsm_done = '0;
      exp_wait += 1;
      chk("bad_done", {bus.error, bus.err_code, bus.retire, bus.fsm_start}, 10'b1100000000);
      tick;
      chk("err_sticky", {bus.error, bus.err_code, bus.instr_ready}, 4'b1100);
      clr_err();

      // Timeout lands exactly TO cycles after WAIT entry.
      to_start(16'hC000);
      for (int k = 1; k <= TO; k++) begin
         tick;
         if (k == TO) chk("to_pre", bus.error, 0);
      end
      tick;
      exp_wait += TO;
      chk("timeout", {bus.error, bus.err_code}, 3'b101);
      clr_err();

      // Multi-hot done including the right bit.
      to_start(16'hC155);
      tick;
      bus.fsm_done = 6'b110000;
      tick;
      bus.fsm_done = '0;
      exp_wait += 1;
      chk("multi_hot", {bus.error, bus.err_code}, 3'b110);
      clr_err();

      // Stray done while idle.
      bus.fsm_done = 6'b000010;
      tick;
      bus.fsm_done = '0;
      chk("stray_idle", {bus.error, bus.err_code}, 3'b111);
      clr_err();
      perf_chk("perf_err");

      // Async reset during WAIT.
      to_start(16'h0123);
      tick;
      #2 reset = 1'b0;
      #1;
      chk("async_rst", {bus.instr_ready, all_outs()}, 0);
      exp_ret  = 0;
      exp_wait = 0;
      tick;
      #3 reset = 1'b1;
      tick;
      chk("rst_rel", bus.instr_ready, 1);

      for (int n = 0; n < 5; n++)
         run_instr({4'hD, 12'($urandom)}, $urandom_range(1, 4), 1'b1);
      perf_chk("perf_store");

      run_instr(16'hE000, 0, 1'b0);
      bus.instruction = 16'hF000;
      bus.instr_valid = 1'b1;
      tick;
      tick;
      chk("halt", {bus.halted, bus.instr_ready, bus.retire, bus.busy}, 4'b1001);
      bus.fsm_done = 6'b000100;
      for (int k = 0; k < 5; k++) tick;
      chk("halt_stays", {bus.halted, bus.instr_ready, bus.error, bus.fsm_start}, 9'h100);
      bus.fsm_done    = '0;
      bus.instr_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
